echip_pattern_clkgen: RTL and testbench

ECHIP_PATTERN_CLKGEN -- requirements
Module: echip_pattern_clkgen

---
 rtl/echip_pattern_clkgen.sv | 126 ++++++++++++
 tb/tb_echip_pattern_clkgen.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/echip_pattern_clkgen.sv
// echip_pattern_clkgen
// Pattern-driven multi-phase clock generator. Each channel replays a
// PLEN-slot bit pattern, one slot per fast clock. New patterns are staged
// in shadow registers and only take effect at a frame boundary, so a
// running clock never sees a torn or shortened pulse. Channels 0 and 1
// carry the non-overlapping phi1/phi2 pair; a commit that would make them
// overlap is refused and flagged.
module echip_pattern_clkgen #(
  parameter  int NCH  = 4,
  parameter  int PLEN = 16,
  localparam int PW   = $clog2(PLEN)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            enable,
  input  logic            cfg_wr_en,
  input  logic [3:0]      cfg_wr_ch,
  input  logic [PLEN-1:0] cfg_wr_data,
  input  logic            cfg_commit,
  output logic [NCH-1:0]  clk_out,
  output logic [PW-1:0]   phase,
  output logic            frame_sync,
  output logic            running,
  output logic            commit_pending,
  output logic            cfg_err
);

  localparam logic [0:0]    S_IDLE  = 1'b0;
  localparam logic [0:0]    S_RUN   = 1'b1;
  localparam logic [PW-1:0] LAST_PH = PW'(PLEN - 1);

  logic [0:0]    r_state;
  logic [PW-1:0] r_phase;
  logic          r_pending;
  logic          r_err;

  logic [0:0]    w_state_next;
  logic [PW-1:0] w_phase_next;
  logic          w_run_next;
  logic          w_boundary;
  logic          w_overlap;
  logic          w_apply;
  logic          w_reject;

  logic [NCH-1:0][PLEN-1:0] w_shadow;

  // A boundary is any idle cycle, or the last slot of a frame that keeps running.
  // Stopping frames are not boundaries; the idle cycle that follows is.
  assign w_boundary = (r_state == S_IDLE) || ((r_phase == LAST_PH) && enable);
  assign w_overlap  = |(w_shadow[0] & w_shadow[1]);
  assign w_apply    = w_boundary && r_pending && !w_overlap;
  assign w_reject   = w_boundary && r_pending && w_overlap;

  // Next state and slot: enable is only honoured at the end of a frame when running.
  always_comb begin
    w_state_next = r_state;
    w_phase_next = r_phase;
    if (r_state == S_IDLE) begin
      w_phase_next = '0;
      if (enable) begin
        w_state_next = S_RUN;
      end
    end else if (r_phase == LAST_PH) begin
      w_phase_next = '0;
      w_state_next = enable ? S_RUN : S_IDLE;
    end else begin
      w_phase_next = r_phase + 1'b1;
    end
  end

  assign w_run_next = (w_state_next == S_RUN);

  // Control registers: state, slot counter, pending commit and sticky error.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state   <= S_IDLE;
      r_phase   <= '0;
      r_pending <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_phase   <= w_phase_next;
      // A commit landing in a boundary cycle re-arms for the next boundary.
      r_pending <= cfg_commit || (r_pending && !w_boundary);
      r_err     <= r_err || w_reject;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      logic [PLEN-1:0] r_shadow;
      logic [PLEN-1:0] r_active;
      logic            r_clk;
      logic [PLEN-1:0] w_active_next;

      // Copy uses the shadow value from before this cycle's write.
      assign w_active_next = w_apply ? r_shadow : r_active;
      assign w_shadow[gi]  = r_shadow;
      assign clk_out[gi]   = r_clk;

      // Per-channel shadow/active storage and the registered clock bit,
      // which is looked up with the same slot index that phase will show.
      always_ff @(posedge clk) begin
        if (!rstn) begin
          r_shadow <= '0;
          r_active <= '0;
          r_clk    <= 1'b0;
        end else begin
          if (cfg_wr_en && (cfg_wr_ch == 4'(gi))) begin
            r_shadow <= cfg_wr_data;
          end
          r_active <= w_active_next;
          r_clk    <= w_run_next && w_active_next[w_phase_next];
        end
      end
    end
  endgenerate

  assign phase          = r_phase;
  assign running        = (r_state == S_RUN);
  assign frame_sync     = (r_state == S_RUN) && (r_phase == '0);
  assign commit_pending = r_pending;
  assign cfg_err        = r_err;

endmodule

// File: tb/tb_echip_pattern_clkgen.sv
// Bench for echip_pattern_clkgen: frame-level reference model, per-cycle
// compare of every output, directed scenarios with literal expectations,
// then a randomized run.
module tb_echip_pattern_clkgen;

  localparam int NCH  = 4;
  localparam int PLEN = 16;
  localparam int PW   = $clog2(PLEN);

  logic            clk = 1'b0;
  logic            rstn;
  logic            enable;
  logic            cfg_wr_en;
  logic [3:0]      cfg_wr_ch;
  logic [PLEN-1:0] cfg_wr_data;
  logic            cfg_commit;
  logic [NCH-1:0]  clk_out;
  logic [PW-1:0]   phase;
  logic            frame_sync;
  logic            running;
  logic            commit_pending;
  logic            cfg_err;

  int checks   = 0;
  int failures = 0;

  echip_pattern_clkgen #(.NCH(NCH), .PLEN(PLEN)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .enable        (enable),
    .cfg_wr_en     (cfg_wr_en),
    .cfg_wr_ch     (cfg_wr_ch),
    .cfg_wr_data   (cfg_wr_data),
    .cfg_commit    (cfg_commit),
    .clk_out       (clk_out),
    .phase         (phase),
    .frame_sync    (frame_sync),
    .running       (running),
    .commit_pending(commit_pending),
    .cfg_err       (cfg_err)
  );

  always #5 clk = ~clk;

  // Reference model: run flag, slot number, pattern tables, pending flag, error flag.
  bit              m_run;
  int              m_phase;
  logic [PLEN-1:0] m_shadow [NCH];
  logic [PLEN-1:0] m_active [NCH];
  bit              m_pending;
  bit              m_err;

  always @(posedge clk) begin
    bit boundary;
    if (!rstn) begin
      m_run = 0; m_phase = 0; m_pending = 0; m_err = 0;
      for (int c = 0; c < NCH; c++) begin
        m_shadow[c] = '0;
        m_active[c] = '0;
      end
    end else begin
      boundary = !m_run || (m_phase == PLEN - 1 && enable);
      if (boundary && m_pending) begin
        if ((m_shadow[0] & m_shadow[1]) != 0) m_err = 1;
        else for (int c = 0; c < NCH; c++) m_active[c] = m_shadow[c];
      end
      m_pending = cfg_commit || (m_pending && !boundary);
      if (cfg_wr_en && int'(cfg_wr_ch) < NCH) m_shadow[cfg_wr_ch] = cfg_wr_data;
      if (!m_run) begin
        m_run = enable; m_phase = 0;
      end else begin
        m_phase = (m_phase + 1) % PLEN;
        if (m_phase == 0 && !enable) m_run = 0;
      end
    end
  end

  // Per-cycle compare of all outputs against the model.
  bit cmp_en = 0;
  int cyc = 0;
  always @(negedge clk) begin
    logic [NCH-1:0] e_clk;
    logic [PW-1:0]  e_ph;
    cyc++;
    if (cmp_en) begin
      for (int c = 0; c < NCH; c++) e_clk[c] = m_run ? m_active[c][m_phase] : 1'b0;
      e_ph = PW'(m_phase);
      checks++;
      if ({clk_out, phase, frame_sync, running, commit_pending, cfg_err} !==
          {e_clk, e_ph, m_run && m_phase == 0, m_run, m_pending, m_err}) begin
        failures++;
        $display("FAIL model cyc=%0d got clk_out=%b phase=%0d fs=%b run=%b pend=%b err=%b want clk_out=%b phase=%0d fs=%b run=%b pend=%b err=%b",
                 cyc, clk_out, phase, frame_sync, running, commit_pending, cfg_err,
                 e_clk, e_ph, m_run && m_phase == 0, m_run, m_pending, m_err);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input int ch, input logic [PLEN-1:0] d);
    cfg_wr_en = 1; cfg_wr_ch = 4'(ch); cfg_wr_data = d;
    step(1);
    cfg_wr_en = 0;
  endtask

  task automatic commit();
    cfg_commit = 1; step(1); cfg_commit = 0;
  endtask

  // Advance until the model shows a running frame at slot p (bounded).
  task automatic wait_phase(input int p);
    int k = 0;
    while (!(m_run && m_phase == p) && k < 100) begin step(1); k++; end
    if (k >= 100) begin
      checks++; failures++;
      $display("FAIL wait_phase p=%0d timed out", p);
    end
  endtask

  initial begin
    rstn = 0; enable = 0; cfg_wr_en = 0; cfg_wr_ch = 0; cfg_wr_data = 0; cfg_commit = 0;
    step(3);
    cmp_en = 1;
    check("reset_clk_out", 32'(clk_out), 0);
    check("reset_flags", {28'd0, running, frame_sync, commit_pending, cfg_err}, 0);
    rstn = 1;

    // Basic patterns, commit in IDLE, then start.
    wr(0, 16'h00FE); wr(1, 16'hFE00); wr(2, 16'hFF00); wr(3, 16'h00FF);
    commit();
    check("pending_after_commit", 32'(commit_pending), 1);
    step(2);
    check("pending_applied_idle", 32'(commit_pending), 0);
    enable = 1;
    step(1);
    check("slot0_clk_out", 32'(clk_out), 32'b1000);
    check("slot0_frame_sync", 32'(frame_sync), 1);
    step(1);
    check("slot1_clk_out", 32'(clk_out), 32'b1001);
    step(7);
    check("slot8_clk_out", 32'(clk_out), 32'b0100);
    step(1);
    check("slot9_clk_out", 32'(clk_out), 32'b0110);
    step(7);
    check("slot0_again_frame_sync", 32'(frame_sync), 1);

    // Commit mid-frame: new ch2 waits for the next frame.
    wait_phase(5);
    cfg_wr_en = 1; cfg_wr_ch = 2; cfg_wr_data = 16'h1FE0; cfg_commit = 1;
    step(1);
    cfg_wr_en = 0; cfg_commit = 0;
    check("pending_phase6", 32'(commit_pending), 1);
    step(7);
    check("old_ch2_slot13", 32'(clk_out[2]), 1);
    step(2);
    check("pending_slot15", 32'(commit_pending), 1);
    step(1);
    check("pending_cleared_slot0", 32'(commit_pending), 0);
    step(5);
    check("new_ch2_slot5", 32'(clk_out[2]), 1);

    // Overlapping phi1/phi2 commit is refused.
    wr(0, 16'h0FF0); wr(1, 16'h00FF);
    commit();
    wait_phase(1);
    check("cfg_err_set", 32'(cfg_err), 1);
    check("cfg_err_pending_clear", 32'(commit_pending), 0);
    check("phi1_unchanged_slot1", 32'(clk_out[0]), 1);

    // Stop at the frame end, and a cancelled stop.
    wait_phase(3);
    enable = 0;
    wait_phase(15);
    check("still_running_slot15", 32'(running), 1);
    step(1);
    check("stopped_outputs", {clk_out, 4'(phase), running, frame_sync}, 0);
    enable = 1;
    wait_phase(3);
    enable = 0;
    wait_phase(10);
    enable = 1;
    wait_phase(15);
    step(1);
    check("stop_cancelled", 32'(running), 1);

    // Out-of-range write, then reset with a commit pending.
    wr(9, 16'hFFFF);
    wait_phase(5);
    commit();
    wait_phase(7);
    rstn = 0;
    step(1);
    check("reset_mid_outputs", 32'(clk_out), 0);
    check("reset_mid_pending", 32'(commit_pending), 0);
    check("reset_mid_err", 32'(cfg_err), 0);
    rstn = 1;

    // Randomized run.
    for (int i = 0; i < 2000; i++) begin
      int r = int'($urandom_range(0, 99));
      enable     = (r < 85);
      cfg_commit = ($urandom_range(0, 19) == 0);
      cfg_wr_en  = ($urandom_range(0, 5) == 0);
      cfg_wr_ch  = 4'($urandom_range(0, 7));
      cfg_wr_data = PLEN'($urandom);
      if (cfg_wr_ch == 1 && $urandom_range(0, 3) != 0) cfg_wr_data = cfg_wr_data & ~m_shadow[0];
      if (cfg_wr_ch == 0 && $urandom_range(0, 3) != 0) cfg_wr_data = cfg_wr_data & ~m_shadow[1];
      rstn = ($urandom_range(0, 299) != 0);
      step(1);
    end
    cfg_wr_en = 0; cfg_commit = 0; rstn = 1;
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
